// File: rtl/output_stream_framer_if.sv
// Stream bundle for output_stream_framer: upstream word channel plus framed downstream channel.
// The framer uses the slave view; the feeding/consuming environment uses the master view.
interface output_stream_framer_if;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    input  m_axis_tready,
    output s_axis_tready,
    output m_axis_tvalid,
    output m_axis_tdata,
    output m_axis_tlast
  );

  modport master (
    output s_axis_tvalid,
    output s_axis_tdata,
    output m_axis_tready,
    input  s_axis_tready,
    input  m_axis_tvalid,
    input  m_axis_tdata,
    input  m_axis_tlast
  );
endinterface

// File: rtl/output_stream_framer.sv
// Purpose: buffer a 32-bit stream in a FWFT FIFO and cut it into FRAME_WORDS frames with TLAST;
//   define CHECKSUM_TRAILER_EN to append an additive checksum trailer beat per frame.
// Latency: 1 cycle push-to-output; backpressure: s_axis_tready drops the cycle after the FIFO fills.

// Generic FWFT FIFO with a registered head word.
// Latency: 1 cycle write-to-head; backpressure: caller must not push when full or pop when empty.
// Depth must be a power of two so pointers wrap naturally.
module osf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     core_clk,
  input  logic                     arst_n,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      fill_q;
  logic [AW:0]      fill_after_pop;
  logic [WIDTH-1:0] head_q;

  assign rd_next        = rd_ptr + AW'(pop_rdy);
  assign fill_after_pop = fill_q - (AW+1)'(pop_rdy);

  always_ff @(posedge core_clk) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
      head_q <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      if (push_vld && !pop_rdy) begin
        fill_q <= fill_q + 1'b1;
      end else if (!push_vld && pop_rdy) begin
        fill_q <= fill_q - 1'b1;
      end
      // New head is the incoming word when nothing older remains, else the next stored word.
      if (push_vld && (fill_after_pop == '0)) begin
        head_q <= push_dat;
      end else if (pop_rdy) begin
        head_q <= mem[rd_next];
      end
    end
  end

  assign head_dat = head_q;
  assign fill     = fill_q;
  assign empty    = (fill_q == '0);
  assign full     = (fill_q == (AW+1)'(DEPTH));
endmodule

module output_stream_framer #(
  parameter int DEPTH       = 16,
  parameter int FRAME_WORDS = 64
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  output_stream_framer_if.slave  axis,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [15:0]            frame_count
);
  logic        ready_en;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [31:0] head;
  logic [15:0] beat_cnt;
  logic        last_beat;
  logic        frame_done;
  logic        m_vld;
  logic [31:0] m_dat;
  logic        m_last;

  // Holds off the upstream for one cycle after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign axis.s_axis_tready = ready_en && !full;
  assign push               = axis.s_axis_tvalid && axis.s_axis_tready;

  osf_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .core_clk (aclk),
    .arst_n   (aresetn),
    .push_vld (push),
    .push_dat (axis.s_axis_tdata),
    .pop_rdy  (pop),
    .head_dat (head),
    .fill     (fill_level),
    .empty    (empty),
    .full     (full)
  );

  assign last_beat = (beat_cnt == 16'(FRAME_WORDS - 1));

`ifdef CHECKSUM_TRAILER_EN
  typedef enum logic {
    ST_DATA,
    ST_TRAILER
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] sum_q;
  logic [31:0] sum_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_DATA;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    m_vld      = 1'b0;
    m_dat      = head;
    m_last     = 1'b0;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_DATA: begin
        m_vld = !empty;
        if (!empty && axis.m_axis_tready) begin
          pop   = 1'b1;
          sum_d = sum_q + head;
          if (last_beat) begin
            state_d = ST_TRAILER;
          end
        end
      end
      ST_TRAILER: begin
        // Sum already includes the final data word; no FIFO pop here.
        m_vld  = 1'b1;
        m_dat  = sum_q;
        m_last = 1'b1;
        if (axis.m_axis_tready) begin
          frame_done = 1'b1;
          sum_d      = '0;
          state_d    = ST_DATA;
        end
      end
      default: begin
        state_d = ST_DATA;
      end
    endcase
  end
`else
  always_comb begin
    m_vld      = !empty;
    m_dat      = head;
    m_last     = !empty && last_beat;
    pop        = !empty && axis.m_axis_tready;
    frame_done = pop && last_beat;
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= last_beat ? 16'd0 : beat_cnt + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  assign axis.m_axis_tvalid = m_vld;
  assign axis.m_axis_tdata  = m_dat;
  assign axis.m_axis_tlast  = m_last;
endmodule

// File: tb/tb_output_stream_framer.sv
// Scoreboard bench for output_stream_framer (DEPTH=16, FRAME_WORDS=4) plus a FRAME_WORDS=1
// instance that streams 65536 frames to exercise frame_count wrap.
module tb_output_stream_framer;
  localparam int FW = 4;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        rst2_n  = 1'b0;
  logic [4:0]  fill_level;
  logic [15:0] frame_count;
  logic [2:0]  fill_level2;
  logic [15:0] frame_count2;

  always #5 aclk = ~aclk;

  output_stream_framer_if bus ();
  output_stream_framer_if wbus ();

  output_stream_framer #(.DEPTH(16), .FRAME_WORDS(FW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .axis        (bus.slave),
    .fill_level  (fill_level),
    .frame_count (frame_count)
  );

  output_stream_framer #(.DEPTH(4), .FRAME_WORDS(1)) dut_wrap (
    .aclk        (aclk),
    .aresetn     (rst2_n),
    .axis        (wbus.slave),
    .fill_level  (fill_level2),
    .frame_count (frame_count2)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_dat[$];
  logic        exp_last[$];
  int          pos        = 0;
  logic [31:0] sum        = 0;
  int          exp_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Expected-response model: frame position, running sum, completed frames.
  task automatic model_push(input logic [31:0] d);
    logic last;
    last = (pos == FW - 1);
    sum  = sum + d;
`ifdef CHECKSUM_TRAILER_EN
    exp_dat.push_back(d);
    exp_last.push_back(1'b0);
    if (last) begin
      exp_dat.push_back(sum);
      exp_last.push_back(1'b1);
    end
`else
    exp_dat.push_back(d);
    exp_last.push_back(last);
`endif
    if (last) begin
      pos = 0;
      sum = 0;
      exp_frames++;
    end else begin
      pos++;
    end
  endtask

  task automatic model_flush();
    exp_dat.delete();
    exp_last.delete();
    pos        = 0;
    sum        = 0;
    exp_frames = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    while (!bus.s_axis_tready && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    if (!bus.s_axis_tready) begin
      fail_now("push_accept");
      bus.s_axis_tvalid = 1'b0;
    end else begin
      @(posedge aclk); #1;
      model_push(d);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_dat.size() != 0 || bus.m_axis_tvalid) && n < 500) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 500) fail_now({name, "_drain"});
    chk({name, "_frames"}, {16'd0, frame_count}, exp_frames);
    chk({name, "_fill"}, {27'd0, fill_level}, 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks hold-under-stall.
  initial begin
    logic        ps;
    logic [31:0] pd;
    logic        pl;
    logic [31:0] d;
    logic        l;
    ps = 1'b0; pd = '0; pl = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        ps = 1'b0;
      end else begin
        if (ps) begin
          chk("hold_valid", {31'd0, bus.m_axis_tvalid}, 32'd1);
          chk("hold_data", bus.m_axis_tdata, pd);
          chk("hold_last", {31'd0, bus.m_axis_tlast}, {31'd0, pl});
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (exp_dat.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got data %h last %0b, want no beat",
                     bus.m_axis_tdata, bus.m_axis_tlast);
          end else begin
            d = exp_dat.pop_front();
            l = exp_last.pop_front();
            chk("out_data", bus.m_axis_tdata, d);
            chk("out_last", {31'd0, bus.m_axis_tlast}, {31'd0, l});
          end
        end
        ps = bus.m_axis_tvalid && !bus.m_axis_tready;
        pd = bus.m_axis_tdata;
        pl = bus.m_axis_tlast;
      end
    end
  end

  initial begin
    bus.s_axis_tvalid  = 1'b0;
    bus.s_axis_tdata   = '0;
    bus.m_axis_tready  = 1'b0;
    wbus.s_axis_tvalid = 1'b0;
    wbus.s_axis_tdata  = 32'hA5;
    wbus.m_axis_tready = 1'b0;
    fork
      begin : main_seq
        int n;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_s_tready", {31'd0, bus.s_axis_tready}, 32'd0);
        chk("rst_m_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
        chk("rst_m_tdata", bus.m_axis_tdata, 32'd0);
        chk("rst_m_tlast", {31'd0, bus.m_axis_tlast}, 32'd0);
        chk("rst_fill", {27'd0, fill_level}, 32'd0);
        chk("rst_frames", {16'd0, frame_count}, 32'd0);
        aresetn = 1'b1;
        chk("rel_tready_lo", {31'd0, bus.s_axis_tready}, 32'd0);
        @(posedge aclk); #1;
        chk("rel_tready_hi", {31'd0, bus.s_axis_tready}, 32'd1);

        // Latency: single word into an empty block.
        bus.m_axis_tready = 1'b1;
        push(32'h5);
        chk("lat_valid", {31'd0, bus.m_axis_tvalid}, 32'd1);
        chk("lat_data", bus.m_axis_tdata, 32'h5);
        chk("lat_last", {31'd0, bus.m_axis_tlast}, 32'd0);
        chk("lat_fill", {27'd0, fill_level}, 32'd1);
        bus.s_axis_tvalid = 1'b0;
        @(posedge aclk); #1;
        chk("lat_fill_after", {27'd0, fill_level}, 32'd0);
        push(32'h6); push(32'h7); push(32'h8);
        bus.s_axis_tvalid = 1'b0;
        drain("lat");

        // Checksum frame with a wrapping sum: 1+2+3+FFFFFFFF = 5.
        push(32'h1); push(32'h2); push(32'h3); push(32'hFFFF_FFFF);
        bus.s_axis_tvalid = 1'b0;
        drain("cks");

`ifdef CHECKSUM_TRAILER_EN
        // Trailer stall while the upstream keeps filling.
        bus.m_axis_tready = 1'b0;
        push(32'h1); push(32'h2); push(32'h3); push(32'hFFFF_FFFF);
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        n = 0;
        while (!(bus.m_axis_tvalid && bus.m_axis_tlast) && n < 50) begin
          @(posedge aclk); #1;
          n++;
        end
        if (n >= 50) fail_now("stall_trailer");
        bus.m_axis_tready = 1'b0;
        fork
          begin
            push(32'h10); push(32'h11); push(32'h12); push(32'h13);
            bus.s_axis_tvalid = 1'b0;
          end
          begin
            for (int i = 0; i < 3; i++) begin
              @(negedge aclk);
              chk("stall_valid", {31'd0, bus.m_axis_tvalid}, 32'd1);
              chk("stall_data", bus.m_axis_tdata, 32'h5);
              chk("stall_last", {31'd0, bus.m_axis_tlast}, 32'd1);
            end
            @(posedge aclk); #1;
            chk("stall_fill", {27'd0, fill_level}, 32'd3);
            bus.m_axis_tready = 1'b1;
          end
        join
        drain("stall");
`endif

        // Backpressure: 17 words offered into a 16-deep FIFO.
        bus.m_axis_tready = 1'b0;
        fork
          begin
            for (int i = 1; i <= 17; i++) push(i);
            bus.s_axis_tvalid = 1'b0;
          end
          begin
            repeat (20) @(posedge aclk);
            #1;
            chk("bp_fill", {27'd0, fill_level}, 32'd16);
            chk("bp_tready", {31'd0, bus.s_axis_tready}, 32'd0);
            bus.m_axis_tready = 1'b1;
            @(negedge aclk);
            chk("bp_tready_before_pop", {31'd0, bus.s_axis_tready}, 32'd0);
            @(negedge aclk);
            chk("bp_tready_after_pop", {31'd0, bus.s_axis_tready}, 32'd1);
            chk("bp_fill_after_pop", {27'd0, fill_level}, 32'd15);
          end
        join
        drain("bp");

        // Reset mid-frame with words still buffered.
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'h100 + i);
        bus.s_axis_tvalid = 1'b0;
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        chk("mrst_s_tready", {31'd0, bus.s_axis_tready}, 32'd0);
        chk("mrst_m_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
        chk("mrst_m_tdata", bus.m_axis_tdata, 32'd0);
        chk("mrst_m_tlast", {31'd0, bus.m_axis_tlast}, 32'd0);
        chk("mrst_fill", {27'd0, fill_level}, 32'd0);
        chk("mrst_frames", {16'd0, frame_count}, 32'd0);
        model_flush();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        chk("mrel_tready_lo", {31'd0, bus.s_axis_tready}, 32'd0);
        @(posedge aclk); #1;
        chk("mrel_tready_hi", {31'd0, bus.s_axis_tready}, 32'd1);
        bus.m_axis_tready = 1'b1;
        push(32'h1); push(32'h2); push(32'h3); push(32'hFFFF_FFFF);
        bus.s_axis_tvalid = 1'b0;
        drain("post_rst");
        chk("post_rst_frames_one", {16'd0, frame_count}, 32'd1);
      end
      begin : wrap_seq
`ifndef CHECKSUM_TRAILER_EN
        int wc;
        int cyc;
        wc  = 0;
        cyc = 0;
        wbus.s_axis_tvalid = 1'b1;
        wbus.m_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        rst2_n = 1'b1;
        while (wc < 65535 && cyc < 70000) begin
          @(negedge aclk);
          cyc++;
          if (wbus.m_axis_tvalid && wbus.m_axis_tready) wc++;
        end
        @(posedge aclk); #1;
        chk("wrap_ffff", {16'd0, frame_count2}, 32'h0000_FFFF);
        while (wc < 65536 && cyc < 70000) begin
          @(negedge aclk);
          cyc++;
          if (wbus.m_axis_tvalid && wbus.m_axis_tready) wc++;
        end
        @(posedge aclk); #1;
        chk("wrap_zero", {16'd0, frame_count2}, 32'd0);
        if (cyc >= 70000) fail_now("wrap_stream");
        wbus.s_axis_tvalid = 1'b0;
`else
        rst2_n = 1'b1;
`endif
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
